// File: rtl/alu_control_seq_if.sv
// Handshake bundle between ID/EX decode and the ALU/muldiv datapath.
// master drives requests and output acceptance; slave is the control block.
interface alu_control_seq_if #(
  parameter int CTL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [1:0]       aluop;
  logic             out_valid;
  logic             out_ready;
  logic [CTL_W-1:0] aluctl;
  logic             illegal;
  logic             multicycle;
  logic             busy;

  modport master (
    output in_valid, funct, aluop, out_ready,
    input  in_ready, out_valid, aluctl,
    input  illegal, multicycle, busy
  );

  modport slave (
    input  in_valid, funct, aluop, out_ready,
    output in_ready, out_valid, aluctl,
    output illegal, multicycle, busy
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with MULT/DIV countdown stall.
// Output slot is a one-entry buffer with valid/ready on both sides.
module alu_control_seq #(
  parameter int CTL_W    = 4,
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_control_seq_if.slave io
);

  localparam int MAX_CYC =
    (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_FULL
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic load;
  logic accept;

  logic [3:0]       dec_ctl;
  logic             dec_ill;
  logic             dec_mc;
  logic [CNT_W-1:0] dec_n;

  logic [CTL_W-1:0] ctl_q;
  logic             ill_q;
  logic             mc_q;

  always_comb begin
    dec_ctl = 4'd2;
    dec_ill = 1'b0;
    dec_mc  = 1'b0;
    dec_n   = CNT_W'(1);
    unique case (1'b1)
      (io.aluop == 2'd1): dec_ctl = 4'd6;
      (io.aluop == 2'd2): begin
        unique case (io.funct)
          6'h20, 6'h21: dec_ctl = 4'd2;
          6'h22, 6'h23: dec_ctl = 4'd6;
          6'h24:        dec_ctl = 4'd0;
          6'h25:        dec_ctl = 4'd1;
          6'h26:        dec_ctl = 4'd13;
          6'h27:        dec_ctl = 4'd12;
          6'h2A:        dec_ctl = 4'd7;
          6'h18, 6'h19: begin
            dec_ctl = 4'd8;
            dec_mc  = 1'b1;
            dec_n   = CNT_W'(MULT_CYC);
          end
          6'h1A, 6'h1B: begin
            dec_ctl = 4'd9;
            dec_mc  = 1'b1;
            dec_n   = CNT_W'(DIV_CYC);
          end
          default: begin
            dec_ctl = 4'd0;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_ctl = 4'd2;
    endcase
  end

  // FULL passes out_ready straight through so a drained slot refills
  assign io.in_ready = !flush &&
    (state == S_EMPTY ||
     (state == S_FULL && io.out_ready));
  assign accept = io.in_valid && io.in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      S_EMPTY: if (accept) load = 1'b1;
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_n = S_FULL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_FULL: begin
        if (accept)           load    = 1'b1;
        else if (io.out_ready) state_n = S_EMPTY;
      end
      default: begin
        state_n = S_EMPTY;
        cnt_n   = '0;
      end
    endcase
    if (load) begin
      if (dec_mc && dec_n > CNT_W'(1)) begin
        state_n = S_WAIT;
        cnt_n   = dec_n - CNT_W'(1);
      end else begin
        state_n = S_FULL;
        cnt_n   = '0;
      end
    end
    if (flush) begin
      state_n = S_EMPTY;
      cnt_n   = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      cnt   <= '0;
      ctl_q <= '0;
      ill_q <= 1'b0;
      mc_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        ctl_q <= CTL_W'(dec_ctl);
        ill_q <= dec_ill;
        mc_q  <= dec_mc;
      end
    end
  end

  assign io.out_valid  = (state == S_FULL);
  assign io.busy       = (state == S_WAIT);
  assign io.aluctl     = ctl_q;
  assign io.illegal    = ill_q;
  assign io.multicycle = mc_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed plus random stimulus for alu_control_seq,
// checked against a transaction-level timing model.
module tb_alu_control_seq;

  localparam int CTL_W    = 4;
  localparam int MULT_CYC = 4;
  localparam int DIV_CYC  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_control_seq_if #(.CTL_W(CTL_W)) bus ();

  alu_control_seq #(
    .CTL_W(CTL_W),
    .MULT_CYC(MULT_CYC),
    .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .io(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the held op, and the edge count at which it becomes visible
  bit       armed = 1'b0;
  bit       have = 1'b0;
  bit       zero_chk = 1'b0;
  int       cyc = 0;
  int       ready_cyc = 0;
  int       m_ctl = 0;
  bit       m_ill = 1'b0;
  bit       m_mc = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(
    input logic [1:0] op, input logic [5:0] fn,
    output int ctl, output bit ill, output bit mc, output int lat);
    ctl = 2; ill = 0; mc = 0; lat = 1;
    if (op == 2'd1) ctl = 6;
    else if (op == 2'd2) begin
      case (fn)
        6'h20, 6'h21: ctl = 2;
        6'h22, 6'h23: ctl = 6;
        6'h24: ctl = 0;
        6'h25: ctl = 1;
        6'h26: ctl = 13;
        6'h27: ctl = 12;
        6'h2A: ctl = 7;
        6'h18, 6'h19: begin ctl = 8; mc = 1; lat = MULT_CYC; end
        6'h1A, 6'h1B: begin ctl = 9; mc = 1; lat = DIV_CYC; end
        default: begin ctl = 0; ill = 1; end
      endcase
    end
  endfunction

  task automatic step(input bit iv, input logic [1:0] op,
                      input logic [5:0] fn, input bit ordy,
                      input bit fl, input bit rn);
    bit exp_ov, exp_rdy, acc;
    int ctl, lat;
    bit ill, mc;
    @(negedge clk);
    exp_ov = have && (cyc >= ready_cyc);
    if (armed) begin
      chk("out_valid", int'(bus.out_valid), int'(exp_ov));
      chk("busy", int'(bus.busy), int'(have && !exp_ov));
      if (have || zero_chk) begin
        chk("aluctl", int'(bus.aluctl), zero_chk ? 0 : m_ctl);
        chk("illegal", int'(bus.illegal), zero_chk ? 0 : int'(m_ill));
        chk("multicycle", int'(bus.multicycle),
            zero_chk ? 0 : int'(m_mc));
      end
    end
    bus.in_valid  = iv;
    bus.aluop     = op;
    bus.funct     = fn;
    bus.out_ready = ordy;
    flush         = fl;
    rst_n         = rn;
    #1;
    exp_rdy = !fl && (!have || (exp_ov && ordy));
    if (armed) chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
    acc = iv && exp_rdy;
    if (!rn) begin
      have = 0;
      zero_chk = 1;
    end else if (fl) begin
      have = 0;
    end else if (acc) begin
      ref_dec(op, fn, ctl, ill, mc, lat);
      have = 1;
      zero_chk = 0;
      m_ctl = ctl; m_ill = ill; m_mc = mc;
      ready_cyc = cyc + lat;
    end else if (exp_ov && ordy) begin
      have = 0;
    end
    cyc++;
    if (!rn) armed = 1'b1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 2'd0, 6'h0, ordy, 0, 1);
  endtask

  initial begin
    logic [5:0] legal [12];
    logic [5:0] fn;
    legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h18, 6'h1A, 6'h19, 6'h1B, 6'h23};
    bus.in_valid = 0; bus.aluop = 0; bus.funct = 0;
    bus.out_ready = 0;

    step(0, 2'd0, 6'h0, 1, 0, 0);
    step(0, 2'd0, 6'h0, 1, 0, 0);
    idle(1, 1);

    step(1, 2'd2, 6'h26, 1, 0, 1);
    idle(2, 1);

    step(1, 2'd0, 6'h00, 1, 0, 1);
    step(1, 2'd1, 6'h00, 1, 0, 1);
    step(1, 2'd2, 6'h2A, 1, 0, 1);
    idle(2, 1);

    step(1, 2'd2, 6'h27, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 2'd1, 6'h0, 0, 0, 1);
    step(1, 2'd0, 6'h00, 1, 0, 1);
    idle(2, 1);

    step(1, 2'd2, 6'h1A, 1, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 2'd1, 6'h0, 0, 0, 1);
    idle(1, 1);
    step(1, 2'd2, 6'h18, 1, 0, 1);
    idle(5, 1);

    step(1, 2'd2, 6'h3F, 1, 0, 1);
    step(1, 2'd0, 6'h3F, 1, 0, 1);
    idle(2, 1);

    step(1, 2'd2, 6'h1A, 1, 0, 1);
    idle(2, 1);
    step(1, 2'd2, 6'h20, 1, 1, 1);
    idle(10, 1);
    step(1, 2'd2, 6'h24, 0, 0, 1);
    step(1, 2'd2, 6'h25, 0, 0, 0);
    idle(3, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 6)
        fn = legal[$urandom_range(0, 11)];
      else
        fn = 6'($urandom);
      step(($urandom_range(0, 9) < 7),
           2'($urandom),
           fn,
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 4),
           !($urandom_range(0, 99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Parametrised, registered successor to the combinational ALU control decoder. It decodes aluop/funct into an ALU control code using the full 6-bit funct field, adds MULT/DIV multi-cycle operations with a countdown stall, and flags illegal funct codes. It sits between the ID/EX decode stage and the ALU/muldiv datapath. Both sides use valid/ready handshakes, and there is a synchronous flush for pipeline squash.

Parameters:
CTL_W, 4, width of aluctl; must be >=4; codes are zero-extended into the upper bits.
MULT_CYC, 4, cycles from MULT/MULTU acceptance to out_valid; must be >=1.
DIV_CYC, 8, cycles from DIV/DIVU acceptance to out_valid; must be >=1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
flush  input  1  synchronous squash of any held or pending op.
in_valid  input  1  funct/aluop valid.
in_ready  output  1  block can accept this cycle.
funct  input  6  instruction funct field.
aluop  input  2  main-decoder ALU op class.
out_valid  output  1  aluctl/illegal/multicycle valid.
out_ready  input  1  consumer accepts output.
aluctl  output  CTL_W  ALU control code.
illegal  output  1  funct unrecognised (aluop=2 only).
multicycle  output  1  held op is MULT/DIV.
busy  output  1  high in WAIT state.

Behaviour:
- Reset: rst_n=0 at a clock edge forces state EMPTY, cnt=0, aluctl=0, illegal=0, multicycle=0, out_valid=0, busy=0. Reset applies in any state, including mid-WAIT. Priority is rst_n > flush > handshake.
- Decode when aluop=0 or 3: ADD (2).
- Decode when aluop=1: SUB (6).
- Decode when aluop=2, by funct:
  - 0x20/0x21 -> 2; 0x22/0x23 -> 6.
  - 0x24 -> 0; 0x25 -> 1; 0x26 -> 13; 0x27 -> 12; 0x2A -> 7.
  - 0x18/0x19 -> 8 (MULT, multicycle); 0x1A/0x1B -> 9 (DIV, multicycle).
  - Any other funct -> 0 with illegal=1.
- illegal and multicycle are only ever 1 when aluop=2.
- Accept = in_valid & in_ready. Decoded values register on the accepting edge and stay stable until the output handshake.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - WAIT: busy=1, in_ready=0, out_valid=0.
  - FULL: out_valid=1, in_ready=out_ready (combinational pass-through).
- Transitions on accept from EMPTY or FULL:
  - Single-cycle op, or multicycle with N=1: go to FULL. Latency is 1 cycle.
  - Multicycle with N>1 (N = MULT_CYC or DIV_CYC): go to WAIT with cnt=N-1.
- WAIT: cnt decrements each cycle; the edge where cnt==1 moves to FULL. out_valid therefore rises exactly N edges after acceptance. in_valid is ignored in WAIT.
- FULL with out_ready=1 and no accept: go to EMPTY.
- FULL with out_ready=1 and accept: back-to-back transfer; the new op replaces the old one with no bubble.
- FULL with out_ready=0: hold all outputs unchanged.
- Flush:
  - flush=1 forces in_ready=0 combinationally.
  - Next edge: state EMPTY, cnt=0, out_valid=0, busy=0.
  - aluctl/illegal/multicycle keep their last value; they are don't-care while out_valid=0.
  - An in_valid presented during flush is not accepted.
- cnt width is $clog2(max(MULT_CYC,DIV_CYC)+1). cnt never underflows and is 0 outside WAIT.
- The out_valid/aluctl/illegal/multicycle/busy outputs are registered (no combinational input->output paths). Only in_ready depends combinationally on out_ready and flush.

Test Plan:
1. Reset, then aluop=2, funct=0x26, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, aluctl=13, illegal=0, multicycle=0. The cycle after that, out_valid=0.
2. Stream aluop=0, 1, then aluop=2/funct=0x2A on consecutive cycles with out_ready=1 -> aluctl 2, 6, 7 on three consecutive cycles with no bubble.
3. Backpressure: FULL with aluctl=12, out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. Then out_ready=1 with a new in_valid -> handshake, and the new code appears the next cycle.
4. aluop=2/funct=0x1A with DIV_CYC=8 -> busy=1 for 7 cycles, in_ready=0, out_valid rises exactly 8 edges after acceptance with aluctl=9, multicycle=1. Repeat with 0x18: out_valid after 4 edges, aluctl=8.
5. aluop=2/funct=0x3F -> aluctl=0, illegal=1. The same funct with aluop=0 -> aluctl=2, illegal=0.
6. flush during WAIT (cycle 3 of DIV), and separately rst_n=0 during FULL -> next edge state EMPTY, out_valid=0, busy=0, in_ready=1. No stale output appears afterwards.
